id_ex_stage: RTL

Decode-to-execute boundary of the 5-stage pipeline. The block takes the two operands read from the register file and applies write-back bypassing to them. It detects load-use hazards and generates the stall/bubble, handles branch flushes, and registers everything the EX stage needs into the ID/EX pipeline register. It sits directly downstream of the register file read ports and directly upstream of the ALU/EX stage.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/hazard_unit.sv | 50 +++++
 rtl/id_ex_stage.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
//----------------------------------------------------------------------
// Module   : pipe_pkg
// Brief    : Shared pipeline constants: control bundle layout and bubble.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

    localparam int CTRL_W        = 10;

    // ALUOp occupies CTRL_ALUOP +: CTRL_ALUOP_W; single-bit flags follow.
    localparam int CTRL_ALUOP    = 0;
    localparam int CTRL_ALUOP_W  = 4;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMTOREG = 8;
    localparam int CTRL_BRANCH   = 9;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/hazard_unit.sv
//----------------------------------------------------------------------
// Module   : hazard_unit
// Brief    : Combinational load-use / WB-read stall detection.
//            Macro WB_BYPASS_EN: when undefined, WB writes also stall.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------
`default_nettype none

module hazard_unit (
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_alusrc,
    input  logic       id_memwrite,
    input  logic       id_branch,
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic       ex_flush,
    input  logic       wb_regwrite,
    input  logic [4:0] wb_rd,
    output logic       stall
);

`ifdef WB_BYPASS_EN
    localparam bit c_WB_STALL = 1'b0;
`else
    localparam bit c_WB_STALL = 1'b1;
`endif

    logic w_uses_rs2;
    logic w_load_use;
    logic w_wb_hit;

    assign w_uses_rs2 = !id_alusrc || id_memwrite || id_branch;

    assign w_load_use = ex_valid && ex_memread && (ex_rd != 5'd0) &&
                        ((ex_rd == id_rs1) || (w_uses_rs2 && (ex_rd == id_rs2)));

    // Without bypass muxes, a same-cycle WB write must land before ID reads.
    assign w_wb_hit   = wb_regwrite && (wb_rd != 5'd0) &&
                        ((wb_rd == id_rs1) || (w_uses_rs2 && (wb_rd == id_rs2)));

    assign stall = rst_n && id_valid && !ex_flush &&
                   (w_load_use || (c_WB_STALL && w_wb_hit));

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
//----------------------------------------------------------------------
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with WB bypass, stall and flush.
//            Macro WB_BYPASS_EN enables the write-back bypass muxes.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------
`default_nettype none

module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   rf_data1,
    input  logic [XLEN-1:0]   rf_data2,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [XLEN-1:0]   ex_op1,
    output logic [XLEN-1:0]   ex_op2,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);

`ifdef WB_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_imm;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_op1;
    logic [XLEN-1:0]   r_op2;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_stall;
    logic              w_wb_live;
    logic [XLEN-1:0]   w_op1;
    logic [XLEN-1:0]   w_op2;
    logic              w_bubble;
    logic              w_count;

    hazard_unit u_hazard (
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_alusrc   (id_ctrl[CTRL_ALUSRC]),
        .id_memwrite (id_ctrl[CTRL_MEMWRITE]),
        .id_branch   (id_ctrl[CTRL_BRANCH]),
        .ex_valid    (r_valid),
        .ex_memread  (r_ctrl[CTRL_MEMREAD]),
        .ex_rd       (r_rd),
        .ex_flush    (ex_flush),
        .wb_regwrite (wb_regwrite),
        .wb_rd       (wb_rd),
        .stall       (w_stall)
    );

    // x0 never matches a live WB write, so it always reads the RF value.
    assign w_wb_live = wb_regwrite && (wb_rd != 5'd0);
    assign w_op1     = (c_BYPASS && w_wb_live && (wb_rd == id_rs1)) ? wb_data : rf_data1;
    assign w_op2     = (c_BYPASS && w_wb_live && (wb_rd == id_rs2)) ? wb_data : rf_data2;

    assign w_count   = ex_flush || w_stall;
    assign w_bubble  = w_count || !id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_imm   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_ctrl  <= CTRL_BUBBLE;
        end else if (w_bubble) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_imm   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_ctrl  <= CTRL_BUBBLE;
        end else begin
            r_valid <= 1'b1;
            r_pc    <= id_pc;
            r_imm   <= id_imm;
            r_rs1   <= id_rs1;
            r_rs2   <= id_rs2;
            r_rd    <= id_rd;
            r_op1   <= w_op1;
            r_op2   <= w_op2;
            r_ctrl  <= id_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_count && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign stall      = w_stall;
    assign ex_valid   = r_valid;
    assign ex_pc      = r_pc;
    assign ex_imm     = r_imm;
    assign ex_rs1     = r_rs1;
    assign ex_rs2     = r_rs2;
    assign ex_rd      = r_rd;
    assign ex_op1     = r_op1;
    assign ex_op2     = r_op2;
    assign ex_ctrl    = r_ctrl;
    assign bubble_cnt = r_cnt;

endmodule

`default_nettype wire
